hazard_ctrl_bp: RTL and testbench

//  Next-generation pipeline hazard controller for the 5-stage datapath.
//  - Generates per-latch enable/flush and pcen for load-use, cache-wait, halt and branch hazards.
//  - Embeds a parametrised pattern history table (PHT) of 2-bit counters: predicts in ID, resolves in MEM.
//  - Keeps saturating stall/flush/mispredict counters for performance readout.

---
 rtl/dp_types_pkg.sv | 47 ++++
 rtl/branch_pht.sv | 36 +++
 rtl/hazard_ctrl_bp.sv | 146 ++++++++++++++
 tb/tb_hazard_ctrl_bp.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dp_types_pkg.sv
// Shared datapath types for the hazard controller and its branch predictor.
package dp_types_pkg;

    typedef logic [4:0]  regbits_t;
    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        STRONG_NT = 2'd0,
        WEAK_NT   = 2'd1,
        WEAK_T    = 2'd2,
        STRONG_T  = 2'd3
    } branch_pred_state_t;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_IMISS,
        HZ_LOADUSE,
        HZ_MISPRED,
        HZ_DWAIT,
        HZ_HALT
    } hazard_cause_t;

    // Bit order of en/flush: [3]=IF/ID [2]=ID/EX [1]=EX/MEM [0]=MEM/WB
    typedef struct packed {
        logic       pcen;
        logic       redirect;
        logic [3:0] en;
        logic [3:0] flush;
    } hz_ctrl_t;

    function automatic branch_pred_state_t pred_next(
        input branch_pred_state_t s,
        input logic               taken
    );
        branch_pred_state_t n;
        n = s;
        unique case (s)
            STRONG_NT: n = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   n = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    n = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  n = taken ? STRONG_T : WEAK_T;
            default:   n = WEAK_NT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_pht.sv
// Pattern history table of 2-bit saturating counters.
// Combinational read port, synchronous saturating write port.
module branch_pht
    import dp_types_pkg::*;
#(
    parameter  int PHT_DEPTH = 16,
    localparam int IDX_W     = $clog2(PHT_DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_taken_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic             wr_taken_i
);

    branch_pred_state_t tbl_q [PHT_DEPTH];
    branch_pred_state_t rd_state;
    branch_pred_state_t wr_state_d;

    assign rd_state   = tbl_q[rd_idx_i];
    assign rd_taken_o = rd_state[1];
    assign wr_state_d = pred_next(tbl_q[wr_idx_i], wr_taken_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < PHT_DEPTH; i++) begin
                tbl_q[i] <= WEAK_NT;
            end
        end else if (wr_en_i) begin
            tbl_q[wr_idx_i] <= wr_state_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl_bp.sv
// 5-stage pipeline hazard controller with embedded PHT branch predictor
// and saturating stall/flush/mispredict performance counters.
module hazard_ctrl_bp
    import dp_types_pkg::*;
#(
    parameter int PHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dmem_req,
    input  logic             ex_dmemREN,
    input  regbits_t         ex_rd,
    input  regbits_t         id_rs,
    input  regbits_t         id_rt,
    input  word_t            id_pc,
    input  logic             mem_branch,
    input  logic             mem_taken,
    input  logic             mem_pred_taken,
    input  word_t            mem_pc,
    input  logic             wb_halt,
    output logic             pred_taken,
    output logic             pcen,
    output logic             redirect,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);

    logic             halted_q, halted_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic          dwait, mispred, loaduse;
    logic          stall_inc, flush_inc;
    hazard_cause_t cause;
    hz_ctrl_t      ctrl;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^{id_pc[31:IDX_W+2], id_pc[1:0],
                              mem_pc[31:IDX_W+2], mem_pc[1:0]};

    assign dwait   = mem_dmem_req & ~dhit;
    assign mispred = mem_branch & (mem_taken != mem_pred_taken);
    assign loaduse = ex_dmemREN & (ex_rd != '0) &
                     ((ex_rd == id_rs) | (ex_rd == id_rt));

    always_comb begin
        cause = HZ_NONE;
        priority case (1'b1)
            halted_q: cause = HZ_HALT;
            dwait:    cause = HZ_DWAIT;
            mispred:  cause = HZ_MISPRED;
            loaduse:  cause = HZ_LOADUSE;
            !ihit:    cause = HZ_IMISS;
            default:  cause = HZ_NONE;
        endcase
    end

    always_comb begin
        ctrl = '{pcen: 1'b1, redirect: 1'b0, en: 4'b1111, flush: 4'b0000};
        unique case (cause)
            HZ_HALT:    ctrl = '{1'b0, 1'b0, 4'b0000, 4'b0000};
            HZ_DWAIT:   ctrl = '{1'b0, 1'b0, 4'b0001, 4'b0001};
            HZ_MISPRED: ctrl = '{1'b1, 1'b1, 4'b1111, 4'b1110};
            HZ_LOADUSE: ctrl = '{1'b0, 1'b0, 4'b0111, 4'b0100};
            HZ_IMISS:   ctrl = '{1'b0, 1'b0, 4'b1111, 4'b1000};
            default:    ctrl = '{1'b1, 1'b0, 4'b1111, 4'b0000};
        endcase
        // Reset cycle: freeze everything and bubble every latch
        if (RST) begin
            ctrl = '{1'b0, 1'b0, 4'b0000, 4'b1111};
        end
    end

    assign pcen         = ctrl.pcen;
    assign redirect     = ctrl.redirect;
    assign if_id_en     = ctrl.en[3];
    assign id_ex_en     = ctrl.en[2];
    assign ex_mem_en    = ctrl.en[1];
    assign mem_wb_en    = ctrl.en[0];
    assign if_id_flush  = ctrl.flush[3];
    assign id_ex_flush  = ctrl.flush[2];
    assign ex_mem_flush = ctrl.flush[1];
    assign mem_wb_flush = ctrl.flush[0];

    branch_pht #(
        .PHT_DEPTH (PHT_DEPTH)
    ) u_pht (
        .clk_i      (CLK),
        .rst_i      (RST),
        .rd_idx_i   (id_pc[IDX_W+1:2]),
        .rd_taken_o (pred_taken),
        .wr_en_i    (mem_branch & ~dwait & ~halted_q),
        .wr_idx_i   (mem_pc[IDX_W+1:2]),
        .wr_taken_i (mem_taken)
    );

    assign stall_inc = (cause == HZ_DWAIT) | (cause == HZ_LOADUSE) |
                       (cause == HZ_IMISS);
    assign flush_inc = (cause == HZ_MISPRED);

    always_comb begin
        halted_d  = halted_q | wb_halt;
        stall_d   = stall_q;
        flush_d   = flush_q;
        mispred_d = mispred_q;
        if (stall_inc && stall_q != '1) stall_d = stall_q + CNT_W'(1);
        if (flush_inc && flush_q != '1) flush_d = flush_q + CNT_W'(1);
        if (flush_inc && mispred_q != '1) mispred_d = mispred_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            halted_q  <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
            mispred_q <= '0;
        end else begin
            halted_q  <= halted_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            mispred_q <= mispred_d;
        end
    end

    assign halted      = halted_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
    assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_hazard_ctrl_bp.sv
// Randomised + directed bench for hazard_ctrl_bp against a behavioural model.
module tb_hazard_ctrl_bp;

    logic        CLK = 1'b0;
    logic        RST, ihit, dhit, mem_dmem_req, ex_dmemREN;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic [31:0] id_pc, mem_pc;
    logic        mem_branch, mem_taken, mem_pred_taken, wb_halt;
    logic        pred_taken, pcen, redirect;
    logic        if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic        halted;
    logic [31:0] stall_cnt, flush_cnt, mispred_cnt;

    int tests = 0;
    int fails = 0;

    int      pht_m [16];
    bit      halt_m;
    longint  st_m, fl_m, mp_m;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    hazard_ctrl_bp #(.PHT_DEPTH(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dmem_req(mem_dmem_req), .ex_dmemREN(ex_dmemREN),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .id_pc(id_pc),
        .mem_branch(mem_branch), .mem_taken(mem_taken),
        .mem_pred_taken(mem_pred_taken), .mem_pc(mem_pc),
        .wb_halt(wb_halt), .pred_taken(pred_taken), .pcen(pcen),
        .redirect(redirect), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    // {pcen, redirect, en[if_id,id_ex,ex_mem,mem_wb], flush[same order]}
    function automatic logic [9:0] model_ctrl();
        bit dw, mp, lu;
        dw = mem_dmem_req && !dhit;
        mp = mem_branch && (mem_taken != mem_pred_taken);
        lu = ex_dmemREN && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        if (RST)          return 10'b00_0000_1111;
        else if (halt_m)  return 10'b00_0000_0000;
        else if (dw)      return 10'b00_0001_0001;
        else if (mp)      return 10'b11_1111_1110;
        else if (lu)      return 10'b00_0111_0100;
        else if (!ihit)   return 10'b00_1111_1000;
        else              return 10'b10_1111_0000;
    endfunction

    task automatic model_edge();
        bit dw, mp, lu;
        dw = mem_dmem_req && !dhit;
        mp = mem_branch && (mem_taken != mem_pred_taken);
        lu = ex_dmemREN && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        if (RST) begin
            foreach (pht_m[i]) pht_m[i] = 1;
            halt_m = 0; st_m = 0; fl_m = 0; mp_m = 0;
        end else if (!halt_m) begin
            if (mem_branch && !dw) begin
                if (mem_taken) pht_m[idx(mem_pc)] = (pht_m[idx(mem_pc)] == 3) ? 3 : pht_m[idx(mem_pc)] + 1;
                else           pht_m[idx(mem_pc)] = (pht_m[idx(mem_pc)] == 0) ? 0 : pht_m[idx(mem_pc)] - 1;
            end
            if (dw || (!mp && (lu || !ihit))) st_m = (st_m == CMAX) ? CMAX : st_m + 1;
            else if (mp) begin
                fl_m = (fl_m == CMAX) ? CMAX : fl_m + 1;
                mp_m = (mp_m == CMAX) ? CMAX : mp_m + 1;
            end
            if (wb_halt) halt_m = 1;
        end
    endtask

    // Compare at negedge, advance model at posedge, release 1ns later
    task automatic step();
        @(negedge CLK);
        chk("ctrl", {pcen, redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
            model_ctrl());
        chk("pred_taken", pred_taken, pht_m[idx(id_pc)] >= 2);
        chk("halted", halted, halt_m);
        chk("stall_cnt", stall_cnt, st_m);
        chk("flush_cnt", flush_cnt, fl_m);
        chk("mispred_cnt", mispred_cnt, mp_m);
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 1; mem_dmem_req = 0; ex_dmemREN = 0;
        ex_rd = 0; id_rs = 0; id_rt = 0; id_pc = 0; mem_pc = 0;
        mem_branch = 0; mem_taken = 0; mem_pred_taken = 0; wb_halt = 0;
    endtask

    task automatic rand_in();
        RST = ($urandom_range(0, 99) < 2);
        ihit = ($urandom_range(0, 9) != 0);
        dhit = ($urandom_range(0, 9) > 2);
        mem_dmem_req = ($urandom_range(0, 9) < 3);
        ex_dmemREN = $urandom_range(0, 1);
        ex_rd = 5'($urandom_range(0, 3));
        id_rs = 5'($urandom_range(0, 3));
        id_rt = 5'($urandom_range(0, 3));
        id_pc = $urandom();
        mem_pc = $urandom();
        mem_branch = $urandom_range(0, 1);
        mem_taken = $urandom_range(0, 1);
        mem_pred_taken = $urandom_range(0, 1);
        wb_halt = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        foreach (pht_m[i]) pht_m[i] = 1;
        halt_m = 0; st_m = 0; fl_m = 0; mp_m = 0;
        idle();
        RST = 1;
        step();
        step();
        RST = 0;
        #1;
        chk("t1_pcen", pcen, 1);
        chk("t1_if_id_en", if_id_en, 1);
        chk("t1_flush", {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, 0);
        chk("t1_pred", pred_taken, 0);
        step();

        ex_dmemREN = 1; ex_rd = 5; id_rt = 5;
        #1;
        chk("t2_pcen", pcen, 0);
        chk("t2_if_id_en", if_id_en, 0);
        chk("t2_id_ex_flush", id_ex_flush, 1);
        step();
        chk("t2_stall_cnt", stall_cnt, 1);
        ex_rd = 0; id_rt = 0;
        #1;
        chk("t2_rd0_pcen", pcen, 1);
        step();
        chk("t2_rd0_stall_cnt", stall_cnt, 1);
        idle();

        mem_branch = 1; mem_taken = 1; mem_pred_taken = 0; mem_pc = 32'h40;
        #1;
        chk("t3_redirect", redirect, 1);
        chk("t3_flushes", {if_id_flush, id_ex_flush, ex_mem_flush}, 3'b111);
        step();
        idle(); id_pc = 32'h40;
        #1;
        chk("t3_pred", pred_taken, 1);
        chk("t3_mispred_cnt", mispred_cnt, 1);
        chk("t3_flush_cnt", flush_cnt, 1);

        mem_branch = 1; mem_taken = 1; mem_pred_taken = 1; mem_pc = 32'h40;
        repeat (3) step();
        mem_taken = 0;
        step();
        #1;
        chk("t4_pred_weak_t", pred_taken, 1);
        step();
        mem_branch = 0;
        #1;
        chk("t4_pred_weak_nt", pred_taken, 0);
        idle();

        mem_branch = 1; mem_taken = 1; mem_pred_taken = 0; mem_pc = 32'h80;
        mem_dmem_req = 1; dhit = 0; id_pc = 32'h80;
        #1;
        chk("t5_redirect_dwait", redirect, 0);
        chk("t5_mem_wb_flush", mem_wb_flush, 1);
        step();
        chk("t5_pht_unchanged", pred_taken, 0);
        dhit = 1;
        #1;
        chk("t5_redirect_resolve", redirect, 1);
        step();
        chk("t5_pht_updated", pred_taken, 1);
        idle();

        wb_halt = 1;
        step();
        wb_halt = 0;
        #1;
        chk("t6_halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            rand_in();
            RST = 0;
            step();
        end
        chk("t6_frozen_en", {if_id_en, id_ex_en, ex_mem_en, mem_wb_en, pcen}, 0);
        idle();
        RST = 1;
        step();
        RST = 0;
        #1;
        chk("t6_halt_clear", halted, 0);
        chk("t6_cnt_clear", stall_cnt, 0);

        for (int i = 0; i < 4000; i++) begin
            rand_in();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
